// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the clock period meter and its matching divider.
package clk_period_meter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEFAULT = 32;

    // Level the divider output sits at out of reset; the synchronizer idles here too.
    localparam logic DIV_RESET_LEVEL = 1'b1;

endpackage

// File: rtl/clk_period_meter_sync.sv
// Multi-flop synchronizer for the measured clock with both-polarity edge detection.
module clk_in_sync
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clk_in_i,
    output logic rise_pulse_o,
    output logic fall_pulse_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= {SYNC_STAGES{DIV_RESET_LEVEL}};
            prev_q <= DIV_RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o      = sync_q[SYNC_STAGES-1];
    assign rise_pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_pulse_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures a slow square wave in CLK cycles, recovers the divider terminal count and declares lock.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TOL            = 0,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             CLK_IN,
    output logic [CNT_W-1:0] DIV_VALUE,
    output logic [CNT_W-1:0] HIGH_LEN,
    output logic [CNT_W-1:0] LOW_LEN,
    output logic [CNT_W:0]   PERIOD,
    output logic             LOCKED,
    output logic             UPDATE,
    output logic             STALLED
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TOL_W    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT - 1);

    logic rise, fall, level;

    clk_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .clk_in_i    (CLK_IN),
        .rise_pulse_o(rise),
        .fall_pulse_o(fall),
        .level_o     (level)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] last_m_q, last_m_d;
    logic             have_last_q, have_last_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] hi_seg_q, hi_seg_d;
    logic [CNT_W-1:0] lo_seg_q, lo_seg_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             locked_q, locked_d;
    logic             update_q, update_d;
    logic             stalled_q, stalled_d;

    logic             edge_det;
    logic             ends_high;
    logic [CNT_W-1:0] seg_len;
    logic [CNT_W-1:0] diff;
    logic             in_tol;
    logic             load;

    assign edge_det  = rise | fall;
    assign ends_high = ~level;
    assign seg_len   = run_cnt_q + ONE;
    assign diff      = (run_cnt_q >= last_m_q) ? (run_cnt_q - last_m_q) : (last_m_q - run_cnt_q);
    assign in_tol    = have_last_q && (diff <= TOL_W);

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        last_m_d    = last_m_q;
        have_last_d = have_last_q;
        match_cnt_d = match_cnt_q;
        hi_seg_d    = hi_seg_q;
        lo_seg_d    = lo_seg_q;
        div_d       = div_q;
        high_d      = high_q;
        low_d       = low_q;
        period_d    = period_q;
        stalled_d   = stalled_q;
        update_d    = 1'b0;
        load        = 1'b0;

        if (edge_det) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != TIMEOUT) begin
            run_cnt_d = run_cnt_q + ONE;
        end

        if (edge_det) begin
            stalled_d = 1'b0;
            // Segment lengths are tracked internally so both halves are valid at lock time.
            if (state_q != S_IDLE) begin
                if (ends_high) hi_seg_d = seg_len;
                else           lo_seg_d = seg_len;
            end
            unique case (state_q)
                S_IDLE: begin
                    state_d     = S_ACQ;
                    match_cnt_d = '0;
                    have_last_d = 1'b0;
                end
                S_ACQ: begin
                    match_cnt_d = in_tol ? (match_cnt_q + ONE) : '0;
                    last_m_d    = run_cnt_q;
                    have_last_d = 1'b1;
                    if (match_cnt_d == LOCK_TGT) begin
                        state_d = S_LOCK;
                        load    = 1'b1;
                    end
                end
                S_LOCK: begin
                    last_m_d = run_cnt_q;
                    if (in_tol) begin
                        load = 1'b1;
                    end else begin
                        state_d     = S_ACQ;
                        match_cnt_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if ((run_cnt_d == TIMEOUT) && (run_cnt_q != TIMEOUT)) begin
            state_d     = S_IDLE;
            stalled_d   = 1'b1;
            have_last_d = 1'b0;
            match_cnt_d = '0;
        end

        if (load) begin
            div_d    = run_cnt_q;
            high_d   = hi_seg_d;
            low_d    = lo_seg_d;
            period_d = {1'b0, hi_seg_d} + {1'b0, lo_seg_d};
            update_d = 1'b1;
        end

        locked_d = (state_d == S_LOCK);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            run_cnt_q   <= '0;
            last_m_q    <= '0;
            have_last_q <= 1'b0;
            match_cnt_q <= '0;
            hi_seg_q    <= '0;
            lo_seg_q    <= '0;
            div_q       <= '0;
            high_q      <= '0;
            low_q       <= '0;
            period_q    <= '0;
            locked_q    <= 1'b0;
            update_q    <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            last_m_q    <= last_m_d;
            have_last_q <= have_last_d;
            match_cnt_q <= match_cnt_d;
            hi_seg_q    <= hi_seg_d;
            lo_seg_q    <= lo_seg_d;
            div_q       <= div_d;
            high_q      <= high_d;
            low_q       <= low_d;
            period_q    <= period_d;
            locked_q    <= locked_d;
            update_q    <= update_d;
            stalled_q   <= stalled_d;
        end
    end

    assign DIV_VALUE = div_q;
    assign HIGH_LEN  = high_q;
    assign LOW_LEN   = low_q;
    assign PERIOD    = period_q;
    assign LOCKED    = locked_q;
    assign UPDATE    = update_q;
    assign STALLED   = stalled_q;

endmodule
